// File: rtl/imem_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared types and helpers for the instruction-memory fetch unit.
//   imem_state_e : controller states (CLEAR sweep, IDLE fetch, PROG load)
//   NOP          : addi x0,x0,0, the default fill word
//   word_parity  : even-parity bit of one instruction word
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int WORD_W = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    PROG  = 2'd2
  } imem_state_e;

  // Even parity: stored bit makes the XOR over data plus parity equal zero.
  function automatic logic word_parity(input logic [WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_unit_if
// Bundles the fetch port, the programming port and the busy flag.
//   master : PC/fetch logic and program loader side
//            (drives fetch_req/fetch_addr and prog_*)
//   slave  : imem_fetch_unit side
//            (drives fetch_ready/valid/instr, fault bits, busy)
// ---------------------------------------------------------------------------
interface imem_fetch_unit_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
);
  localparam int AW = $clog2(DEPTH);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [XLEN-1:0]   fetch_instr;
  logic              fetch_misaligned;
  logic              fetch_oob;
  logic              fetch_parity_err;
  logic              prog_en;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [XLEN-1:0]   prog_data;
  logic              prog_inj_err;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, prog_en, prog_we, prog_addr, prog_data, prog_inj_err,
    input  fetch_ready, fetch_valid, fetch_instr, fetch_misaligned, fetch_oob,
           fetch_parity_err, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, prog_en, prog_we, prog_addr, prog_data, prog_inj_err,
    output fetch_ready, fetch_valid, fetch_instr, fetch_misaligned, fetch_oob,
           fetch_parity_err, busy
  );

endinterface

// File: rtl/imem_fetch_unit_array.sv
// ---------------------------------------------------------------------------
// imem_array
// Word storage with one write port and one registered read port.
//   clk   in  clock
//   we    in  write enable; waddr/wdata written at the clock edge
//   re    in  read enable; rdata loads mem[raddr] at the clock edge
//   rdata out registered read data, holds while re=0
// W is the stored word width (instruction word plus optional parity bit).
// ---------------------------------------------------------------------------
module imem_array #(
  parameter int W     = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_r [DEPTH];
  logic [W-1:0] rdata_r;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; the last word read is held between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/imem_fetch_unit.sv
// ---------------------------------------------------------------------------
// imem_fetch_unit
// Loadable instruction memory with a 1-cycle registered fetch port.
// After reset a sweep writes FILL_WORD to every word (busy=1), then the
// block serves byte-addressed, word-aligned fetches (IDLE) or accepts
// program writes (PROG).
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    slave modport of imem_fetch_unit_if:
//          fetch_req/fetch_addr -> fetch_ready, fetch_valid, fetch_instr,
//          fetch_misaligned, fetch_oob, fetch_parity_err;
//          prog_en/prog_we/prog_addr/prog_data/prog_inj_err; busy
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word and flag mismatches on fetch (prog_inj_err flips the stored bit).
// ---------------------------------------------------------------------------
import imem_pkg::*;

module imem_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 64,
  parameter int              ADDR_W    = 32,
  parameter logic [XLEN-1:0] FILL_WORD = NOP
) (
  input logic               clk,
  input logic               reset,
  imem_fetch_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = XLEN + PW;

  localparam logic [AW-1:0]     LAST_IDX = AW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_W  = ADDR_W'(DEPTH);

  imem_state_e   state_r;
  logic [AW-1:0] cnt_r;
  logic          busy_r;

  logic          ready_s;
  logic          misal_s;
  logic          oob_s;
  logic          accept_s;
  logic          rd_en_s;
  logic [AW-1:0] rd_idx_s;

  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [MW-1:0] wdata_s;
  logic [MW-1:0] rdata_s;

  logic          valid_r;
  logic          misal_r;
  logic          oob_r;
  logic          fill_sel_r;
  logic          chk_r;

  // Controller: reset sweep, then IDLE/PROG selected by prog_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CLEAR;
      cnt_r   <= {AW{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          if (cnt_r == LAST_IDX) begin
            cnt_r   <= {AW{1'b0}};
            busy_r  <= 1'b0;
            state_r <= bus.prog_en ? PROG : IDLE;
          end else begin
            cnt_r   <= cnt_r + AW'(1);
          end
        end
        IDLE: begin
          if (bus.prog_en) begin
            state_r <= PROG;
          end
        end
        PROG: begin
          if (!bus.prog_en) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= CLEAR;
          cnt_r   <= {AW{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Address decode; oob compares the full word address, so high address
  // bits that alias onto a valid index still fault.
  always_comb begin
    ready_s  = (state_r == IDLE) && !reset;
    misal_s  = (bus.fetch_addr[1:0] != 2'b00);
    oob_s    = ({2'b00, bus.fetch_addr[ADDR_W-1:2]} >= DEPTH_W);
    rd_idx_s = bus.fetch_addr[AW+1:2];
    accept_s = bus.fetch_req && ready_s;
    rd_en_s  = accept_s && !misal_s && !oob_s;
  end

  // Single write port shared by the sweep (CLEAR) and the loader (PROG).
  always_comb begin
    we_s    = 1'b0;
    waddr_s = cnt_r;
    wdata_s = {MW{1'b0}};
    if (reset) begin
      we_s = 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          we_s    = 1'b1;
          waddr_s = cnt_r;
`ifdef IMEM_PARITY_EN
          wdata_s = {word_parity(FILL_WORD), FILL_WORD};
`else
          wdata_s = FILL_WORD;
`endif
        end
        PROG: begin
          we_s    = bus.prog_we;
          waddr_s = bus.prog_addr;
`ifdef IMEM_PARITY_EN
          wdata_s = {word_parity(bus.prog_data) ^ bus.prog_inj_err, bus.prog_data};
`else
          wdata_s = bus.prog_data;
`endif
        end
        IDLE: begin
          we_s = 1'b0;
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end
  end

  imem_array #(
    .W     (MW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .re    (rd_en_s),
    .raddr (rd_idx_s),
    .rdata (rdata_s)
  );

  // Fetch response flags; everything except the valid pulse holds between
  // fetches so fetch_instr and the fault bits keep their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r    <= 1'b0;
      misal_r    <= 1'b0;
      oob_r      <= 1'b0;
      fill_sel_r <= 1'b1;
      chk_r      <= 1'b0;
    end else if (accept_s) begin
      valid_r    <= 1'b1;
      misal_r    <= misal_s;
      oob_r      <= oob_s;
      fill_sel_r <= misal_s || oob_s;
      chk_r      <= !(misal_s || oob_s);
    end else begin
      valid_r    <= 1'b0;
    end
  end

  assign bus.fetch_ready      = ready_s;
  assign bus.fetch_valid      = valid_r;
  assign bus.fetch_misaligned = misal_r;
  assign bus.fetch_oob        = oob_r;
  assign bus.busy             = busy_r;
  // Faulting fetches never read the array, so the held read data is masked.
  assign bus.fetch_instr      = fill_sel_r ? FILL_WORD : rdata_s[XLEN-1:0];

`ifdef IMEM_PARITY_EN
  assign bus.fetch_parity_err = chk_r && (word_parity(rdata_s[XLEN-1:0]) != rdata_s[XLEN]);
`else
  logic unused_inj_s;
  assign unused_inj_s         = bus.prog_inj_err ^ chk_r;
  assign bus.fetch_parity_err = 1'b0;
`endif

endmodule
